// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared states, opcodes and control encodings for the multicycle MIPS controller (MIPS_CTRL_ILLEGAL_TRAP_EN adds TRAP)
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        ,S_TRAP
`endif
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// rtl/mips_multicycle_ctrl_alu_decoder.sv - combinational aluop/funct to alu_control decoder
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_valid
);

    logic [2:0] funct_ctrl;

    // funct_valid ignores aluop so DECODE can screen R-type instructions early
    always_comb begin
        funct_ctrl  = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  funct_ctrl = ALU_ADD;
            FN_SUB:  funct_ctrl = ALU_SUB;
            FN_AND:  funct_ctrl = ALU_AND;
            FN_OR:   funct_ctrl = ALU_OR;
            FN_SLT:  funct_ctrl = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_ctrl;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM (MIPS_CTRL_ILLEGAL_TRAP_EN enables TRAP on illegal instructions)
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       illegal_op
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state, state_nxt, illegal_target;
    logic [3:0] wcnt, wcnt_nxt;
    logic       mem_done;
    logic [1:0] aluop;
    logic       funct_valid;
    logic       pc_write, branch;
    logic       ir_write_s, mem_write_s, reg_write_s;

    assign mem_done = (wcnt == WAIT_LAST);

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    assign illegal_target = S_TRAP;
    assign illegal_op     = ~reset & (state == S_TRAP);
`else
    assign illegal_target = S_FETCH;
    assign illegal_op     = 1'b0;
`endif

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct       (funct),
        .alu_control (alu_control),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wcnt_nxt    = '0;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RT;
        pc_src      = PCSRC_ALU;
        aluop       = ALUOP_ADD;
        pc_write    = 1'b0;
        branch      = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                ir_write_s = mem_done;
                pc_write   = mem_done;
                if (mem_done) state_nxt = S_DECODE;
                else          wcnt_nxt  = wcnt + 4'd1;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = funct_valid ? S_EXECUTE : illegal_target;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JUMP;
                    default:      state_nxt = illegal_target;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_done) state_nxt = S_MEMWB;
                else          wcnt_nxt  = wcnt + 4'd1;
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_s = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_MEMWR: begin
                // single strobe on the last wait cycle, once the address has settled
                iord        = 1'b1;
                mem_write_s = mem_done;
                if (mem_done) state_nxt = S_FETCH;
                else          wcnt_nxt  = wcnt + 4'd1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_s = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_nxt = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_JUMP: begin
                pc_src    = PCSRC_JUMP;
                pc_write  = 1'b1;
                state_nxt = S_FETCH;
            end
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: state_nxt = S_TRAP;
`endif
            default: state_nxt = S_FETCH;
        endcase
    end

    // write enables are squashed while reset is high so an abandoned instruction leaves no trace
    assign pc_en     = ~reset & (pc_write | (branch & zero));
    assign ir_write  = ~reset & ir_write_s;
    assign mem_write = ~reset & mem_write_s;
    assign reg_write = ~reset & reg_write_s;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized self-checking bench for mips_multicycle_ctrl (MEM_WAIT 0 and 2)
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic       illegal_op;
    } ctrl_t;

    localparam int TRAP_HOLD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_v [2];
    logic [5:0] op_v [2];
    logic [5:0] funct_v [2];
    logic       zero_v [2];
    logic       pc_en_v [2], iord_v [2], mem_write_v [2], ir_write_v [2];
    logic       reg_dst_v [2], mem_to_reg_v [2], reg_write_v [2], alu_src_a_v [2];
    logic [1:0] alu_src_b_v [2], pc_src_v [2];
    logic [2:0] alu_control_v [2];
    logic       illegal_op_v [2];

    int checks = 0;
    int errors = 0;
    int mw_of [2] = '{0, 2};
    ctrl_t exp_q [$];

    mips_multicycle_ctrl #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .reset(reset_v[0]), .op(op_v[0]), .funct(funct_v[0]), .zero(zero_v[0]),
        .pc_en(pc_en_v[0]), .iord(iord_v[0]), .mem_write(mem_write_v[0]), .ir_write(ir_write_v[0]),
        .reg_dst(reg_dst_v[0]), .mem_to_reg(mem_to_reg_v[0]), .reg_write(reg_write_v[0]),
        .alu_src_a(alu_src_a_v[0]), .alu_src_b(alu_src_b_v[0]), .pc_src(pc_src_v[0]),
        .alu_control(alu_control_v[0]), .illegal_op(illegal_op_v[0])
    );

    mips_multicycle_ctrl #(.MEM_WAIT(2)) dut2 (
        .clk(clk), .reset(reset_v[1]), .op(op_v[1]), .funct(funct_v[1]), .zero(zero_v[1]),
        .pc_en(pc_en_v[1]), .iord(iord_v[1]), .mem_write(mem_write_v[1]), .ir_write(ir_write_v[1]),
        .reg_dst(reg_dst_v[1]), .mem_to_reg(mem_to_reg_v[1]), .reg_write(reg_write_v[1]),
        .alu_src_a(alu_src_a_v[1]), .alu_src_b(alu_src_b_v[1]), .pc_src(pc_src_v[1]),
        .alu_control(alu_control_v[1]), .illegal_op(illegal_op_v[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ctrl_t observed(input int d);
        ctrl_t c;
        c.pc_en       = pc_en_v[d];
        c.iord        = iord_v[d];
        c.mem_write   = mem_write_v[d];
        c.ir_write    = ir_write_v[d];
        c.reg_dst     = reg_dst_v[d];
        c.mem_to_reg  = mem_to_reg_v[d];
        c.reg_write   = reg_write_v[d];
        c.alu_src_a   = alu_src_a_v[d];
        c.alu_src_b   = alu_src_b_v[d];
        c.pc_src      = pc_src_v[d];
        c.alu_control = alu_control_v[d];
        c.illegal_op  = illegal_op_v[d];
        return c;
    endfunction

    function automatic logic [4:0] enables(input int d);
        return {pc_en_v[d], ir_write_v[d], mem_write_v[d], reg_write_v[d], illegal_op_v[d]};
    endfunction

    function automatic ctrl_t idle();
        ctrl_t c = '0;
        c.alu_control = 3'b010;
        return c;
    endfunction

    // ALU function table for R-type; -1 marks an unsupported funct
    function automatic int rtype_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    function automatic bit is_illegal(input logic [5:0] o, input logic [5:0] fn);
        if (o == 6'b000000) return rtype_alu(fn) < 0;
        return !(o inside {6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
    endfunction

    // Expected per-cycle outputs of one whole instruction, starting at its fetch
    function automatic void build_seq(input int mw, input logic [5:0] o, input logic [5:0] fn, input logic z);
        ctrl_t c;
        exp_q.delete();
        for (int i = 0; i <= mw; i++) begin
            c = idle(); c.alu_src_b = 2'b01;
            if (i == mw) begin c.ir_write = 1; c.pc_en = 1; end
            exp_q.push_back(c);
        end
        c = idle(); c.alu_src_b = 2'b11; exp_q.push_back(c);
        if (is_illegal(o, fn)) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            for (int i = 0; i < TRAP_HOLD; i++) begin
                c = idle(); c.illegal_op = 1; exp_q.push_back(c);
            end
`endif
            return;
        end
        case (o)
            6'b100011, 6'b101011: begin
                c = idle(); c.alu_src_a = 1; c.alu_src_b = 2'b10; exp_q.push_back(c);
                for (int i = 0; i <= mw; i++) begin
                    c = idle(); c.iord = 1;
                    if (o == 6'b101011 && i == mw) c.mem_write = 1;
                    exp_q.push_back(c);
                end
                if (o == 6'b100011) begin
                    c = idle(); c.mem_to_reg = 1; c.reg_write = 1; exp_q.push_back(c);
                end
            end
            6'b000000: begin
                c = idle(); c.alu_src_a = 1; c.alu_control = 3'(rtype_alu(fn)); exp_q.push_back(c);
                c = idle(); c.reg_dst = 1; c.reg_write = 1; exp_q.push_back(c);
            end
            6'b000100: begin
                c = idle(); c.alu_src_a = 1; c.alu_control = 3'b110; c.pc_src = 2'b01; c.pc_en = z;
                exp_q.push_back(c);
            end
            6'b001000: begin
                c = idle(); c.alu_src_a = 1; c.alu_src_b = 2'b10; exp_q.push_back(c);
                c = idle(); c.reg_write = 1; exp_q.push_back(c);
            end
            default: begin
                c = idle(); c.pc_src = 2'b10; c.pc_en = 1; exp_q.push_back(c);
            end
        endcase
    endfunction

    task automatic apply_reset(input int d, input int n);
        reset_v[d] = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("d%0d_rst_en_%0d", d, i), 32'(enables(d)), 32'd0);
            @(posedge clk); #1;
        end
        reset_v[d] = 1'b0;
    endtask

    // Checks the first `upto` cycles (all when upto < 0); inputs change #1 after the edge
    task automatic run_instr(input int d, input logic [5:0] o, input logic [5:0] fn, input logic z, input int upto);
        int n;
        op_v[d] = o; funct_v[d] = fn; zero_v[d] = z;
        build_seq(mw_of[d], o, fn, z);
        n = (upto < 0) ? exp_q.size() : upto;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("d%0d_op%b_fn%b_z%0d_c%0d", d, o, fn, z, i), 32'(observed(d)), 32'(exp_q[i]));
            @(posedge clk); #1;
        end
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        if (upto < 0 && is_illegal(o, fn)) apply_reset(d, 1);
`endif
    endtask

    task automatic run_random(input int d, input int count);
        logic [5:0] o, fn;
        for (int k = 0; k < count; k++) begin
            fn = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 7))
                0: o = 6'b100011;
                1: o = 6'b101011;
                2: begin
                    o = 6'b000000;
                    case ($urandom_range(0, 4))
                        0: fn = 6'b100000; 1: fn = 6'b100010; 2: fn = 6'b100100;
                        3: fn = 6'b100101; default: fn = 6'b101010;
                    endcase
                end
                3: o = 6'b000100;
                4: o = 6'b001000;
                5: o = 6'b000010;
                6: o = 6'($urandom_range(0, 63));
                default: o = 6'b000000;
            endcase
            run_instr(d, o, fn, 1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset_v[d] = 1'b1; op_v[d] = '0; funct_v[d] = 6'b100000; zero_v[d] = 1'b0;
        end
        @(posedge clk); #1;
        apply_reset(0, 3);

        run_instr(0, 6'b100011, 6'b000000, 1'b0, -1);
        run_instr(0, 6'b000000, 6'b101010, 1'b0, -1);
        run_instr(0, 6'b000000, 6'b100010, 1'b0, -1);
        run_instr(0, 6'b000000, 6'b100100, 1'b1, -1);
        run_instr(0, 6'b000000, 6'b100101, 1'b0, -1);
        run_instr(0, 6'b000100, 6'b000000, 1'b1, -1);
        run_instr(0, 6'b000100, 6'b000000, 1'b0, -1);
        run_instr(0, 6'b101011, 6'b000000, 1'b0, -1);
        run_instr(0, 6'b001000, 6'b000000, 1'b0, -1);
        run_instr(0, 6'b000010, 6'b000000, 1'b0, -1);
        run_instr(0, 6'b111111, 6'b000000, 1'b0, -1);
        run_instr(0, 6'b000000, 6'b111000, 1'b0, -1);

        // abandon an add while it sits in EXECUTE
        run_instr(0, 6'b000000, 6'b100000, 1'b0, 2);
        apply_reset(0, 3);
        run_instr(0, 6'b000010, 6'b000000, 1'b0, -1);
        run_random(0, 40);
        reset_v[0] = 1'b1;

        apply_reset(1, 2);
        run_instr(1, 6'b101011, 6'b000000, 1'b0, -1);
        run_instr(1, 6'b100011, 6'b000000, 1'b0, -1);
        run_instr(1, 6'b000100, 6'b000000, 1'b1, -1);
        run_instr(1, 6'b111111, 6'b000000, 1'b0, -1);
        run_random(1, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
